// File: rtl/mem_port_ctrl_if.sv
// Requester/memory bundle for mem_port_ctrl.
// Memory-mode encodings are defined here when the shared signals header is absent.
`ifndef memModeNone
`define memModeNone 2'b00
`endif
`ifndef memModeIn
`define memModeIn 2'b01
`endif
`ifndef memModeOut
`define memModeOut 2'b10
`endif

interface mem_port_ctrl_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
);
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_ack;
    logic [DW-1:0] f_data;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic [1:0]    mem_mode;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    // Controller side
    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output f_ack, f_data, d_ack, d_rdata, mem_mode, mem_addr, mem_wdata, busy
    );

    // Requester/memory side
    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  f_ack, f_data, d_ack, d_rdata, mem_mode, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_ctrl.sv
// Memory-port controller: arbitrates fetch and data requesters onto a single
// 16-bit memory with one-cycle registered read latency. All outputs registered.
// Optional round-robin arbitration: define MEM_PORT_CTRL_RR_EN.
module mem_port_ctrl #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
) (
    input  logic           clk,
    input  logic           reset,
    mem_port_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StIssue, StCapt, StDone} state_e;
    typedef enum logic [1:0] {OwnNone, OwnFetch, OwnData} owner_e;

    state_e        r_state, w_state;
    owner_e        r_owner, w_owner;
    logic [1:0]    r_mem_mode, w_mem_mode;
    logic [AW-1:0] r_mem_addr, w_mem_addr;
    logic [DW-1:0] r_mem_wdata, w_mem_wdata;
    logic [DW-1:0] r_f_data, w_f_data;
    logic [DW-1:0] r_d_rdata, w_d_rdata;
    logic          r_f_ack, w_f_ack;
    logic          r_d_ack, w_d_ack;
    logic          r_busy, w_busy;
    logic          w_grant_data;
`ifdef MEM_PORT_CTRL_RR_EN
    logic          r_rr_ptr, w_rr_ptr;  // 0: fetch preferred, 1: data preferred
`endif

    // Arbitration: does the data port win if a grant happens this cycle
    always_comb begin
`ifdef MEM_PORT_CTRL_RR_EN
        w_grant_data = bus.d_req && (!bus.f_req || r_rr_ptr);
`else
        w_grant_data = bus.d_req;
`endif
    end

    // Next-state and next-output logic
    always_comb begin
        w_state     = r_state;
        w_owner     = r_owner;
        w_mem_mode  = `memModeNone;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_f_data    = r_f_data;
        w_d_rdata   = r_d_rdata;
        w_f_ack     = 1'b0;
        w_d_ack     = 1'b0;
`ifdef MEM_PORT_CTRL_RR_EN
        w_rr_ptr    = r_rr_ptr;
`endif
        unique case (r_state)
            StIdle: begin
                if (bus.f_req || bus.d_req) begin
                    w_state = StIssue;
                    if (w_grant_data) begin
                        w_owner     = OwnData;
                        w_mem_addr  = bus.d_addr;
                        w_mem_wdata = bus.d_wdata;
                        w_mem_mode  = bus.d_we ? `memModeIn : `memModeOut;
                    end else begin
                        w_owner    = OwnFetch;
                        w_mem_addr = bus.f_addr;
                        w_mem_mode = `memModeOut;
                    end
`ifdef MEM_PORT_CTRL_RR_EN
                    // Point at the port that was not just granted
                    w_rr_ptr = !w_grant_data;
`endif
                end
            end
            StIssue: begin
                // Memory acts at this cycle's closing edge; a write is complete then
                if (r_mem_mode == `memModeIn) begin
                    w_state = StDone;
                    w_d_ack = (r_owner == OwnData);
                end else begin
                    w_state = StCapt;
                end
            end
            StCapt: begin
                w_state = StDone;
                if (r_owner == OwnData) begin
                    w_d_rdata = bus.mem_rdata;
                    w_d_ack   = 1'b1;
                end else begin
                    w_f_data = bus.mem_rdata;
                    w_f_ack  = 1'b1;
                end
            end
            StDone: begin
                w_state = StIdle;
                w_owner = OwnNone;
            end
        endcase
        w_busy = (w_state != StIdle);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= StIdle;
            r_owner     <= OwnNone;
            r_mem_mode  <= `memModeNone;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_f_data    <= '0;
            r_d_rdata   <= '0;
            r_f_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_owner     <= w_owner;
            r_mem_mode  <= w_mem_mode;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_f_data    <= w_f_data;
            r_d_rdata   <= w_d_rdata;
            r_f_ack     <= w_f_ack;
            r_d_ack     <= w_d_ack;
            r_busy      <= w_busy;
        end
    end

`ifdef MEM_PORT_CTRL_RR_EN
    // Round-robin pointer register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= 1'b0;
        end else begin
            r_rr_ptr <= w_rr_ptr;
        end
    end
`endif

    assign bus.f_ack     = r_f_ack;
    assign bus.f_data    = r_f_data;
    assign bus.d_ack     = r_d_ack;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.mem_mode  = r_mem_mode;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = r_busy;
endmodule
